// File: rtl/conv_frame_loader.sv
// conv_frame_loader: assembles 3x3 kernel taps, a bias byte and an IMG_W x IMG_H image from a byte stream into flat buffers.
// Latency: frame_valid rises 1 cycle after the final image beat is accepted; frame_err pulses 1 cycle after an offending beat.
// Backpressure: s_ready is registered from state only and is low while a completed frame is held awaiting frame_ack.
// Optional build macro CONV_LOADER_ZERO_BORDER_EN: image pixels on the outer ring are stored as zero.
module conv_frame_loader #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 8,
    parameter int N_TAPS = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    input  logic [PIX_W-1:0]               s_data,
    input  logic                           s_last,
    output logic                           s_ready,
    input  logic                           frame_ack,
    output logic                           frame_valid,
    output logic                           frame_err,
    output logic [PIX_W*IMG_W*IMG_H-1:0]   image_buffer,
    output logic [PIX_W*N_TAPS-1:0]        kernel,
    output logic [PIX_W-1:0]               bias
);

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIX - 1);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

    typedef enum logic [1:0] {S_KERNEL, S_BIAS, S_IMAGE, S_HOLD} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_nxt;
    logic               beat;
    logic               s_ready_q, frame_valid_q, frame_err_q;
    logic [PIX_W-1:0]   pix_dat;
    logic [PIX_W*N_PIX-1:0]  image_q;
    logic [PIX_W*N_TAPS-1:0] kernel_q;
    logic [PIX_W-1:0]        bias_q;

    assign beat = s_valid && s_ready_q;

    // Next-state, beat counter and framing-error decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        case (state)
            S_KERNEL: if (beat) begin
                if (s_last) begin
                    err_nxt = 1'b1;
                end else if (cnt == LAST_TAP) begin
                    cnt_nxt   = '0;
                    state_nxt = S_BIAS;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_BIAS: if (beat) begin
                if (s_last) err_nxt = 1'b1;
                else        state_nxt = S_IMAGE;
            end
            S_IMAGE: if (beat) begin
                if (cnt == LAST_PIX) begin
                    // Final pixel: counter parks here until the frame is released
                    if (s_last) state_nxt = S_HOLD;
                    else        err_nxt   = 1'b1;
                end else if (s_last) begin
                    err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HOLD: if (frame_ack) begin
                cnt_nxt   = '0;
                state_nxt = S_KERNEL;
            end
            default: state_nxt = S_KERNEL;
        endcase
        if (err_nxt) begin
            cnt_nxt   = '0;
            state_nxt = S_KERNEL;
        end
    end

    // State, counter and registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_KERNEL;
            cnt           <= '0;
            s_ready_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            s_ready_q     <= (state_nxt != S_HOLD);
            frame_valid_q <= (state_nxt == S_HOLD);
            frame_err_q   <= err_nxt;
        end
    end

`ifdef CONV_LOADER_ZERO_BORDER_EN
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             on_border;

    // Row/column position of the current image beat; idle at origin outside the image phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (state != S_IMAGE) begin
            col <= '0;
            row <= '0;
        end else if (beat) begin
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                if (row != ROW_W'(IMG_H - 1)) row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign on_border = (row == '0) || (row == ROW_W'(IMG_H - 1)) ||
                       (col == '0) || (col == COL_W'(IMG_W - 1));
    assign pix_dat   = on_border ? '0 : s_data;
`else
    assign pix_dat = s_data;
`endif

    // Buffer writes: the accepted byte lands in the slot addressed by state and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_q <= '0;
            bias_q   <= '0;
            image_q  <= '0;
        end else if (beat) begin
            case (state)
                S_KERNEL: begin
                    for (int t = 0; t < N_TAPS; t++) begin
                        if (cnt == CNT_W'(t)) kernel_q[t*PIX_W +: PIX_W] <= s_data;
                    end
                end
                S_BIAS: bias_q <= s_data;
                S_IMAGE: begin
                    for (int p = 0; p < N_PIX; p++) begin
                        if (cnt == CNT_W'(p)) image_q[p*PIX_W +: PIX_W] <= pix_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign image_buffer = image_q;
    assign kernel       = kernel_q;
    assign bias         = bias_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// tb_conv_frame_loader: stream-position reference model plus table-driven frame scenarios and hand-written corner sequences.
// Latency: frame_valid/frame_err sampled on the falling edge right after the accepting rising edge.
// Backpressure: beats are offered with s_valid and held until s_ready is seen high at a rising edge.
module tb_conv_frame_loader;

    localparam int IMG_W     = 28;
    localparam int IMG_H     = 28;
    localparam int PIX_W     = 8;
    localparam int N_TAPS    = 9;
    localparam int N_PIX     = IMG_W * IMG_H;
    localparam int FRAME_LEN = N_TAPS + 1 + N_PIX;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     s_valid;
    logic [PIX_W-1:0]         s_data;
    logic                     s_last;
    logic                     s_ready;
    logic                     frame_ack;
    logic                     frame_valid;
    logic                     frame_err;
    logic [PIX_W*N_PIX-1:0]   image_buffer;
    logic [PIX_W*N_TAPS-1:0]  kernel;
    logic [PIX_W-1:0]         bias;

    conv_frame_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .N_TAPS(N_TAPS)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .frame_ack(frame_ack), .frame_valid(frame_valid),
        .frame_err(frame_err), .image_buffer(image_buffer), .kernel(kernel), .bias(bias)
    );

    always #5 clk = ~clk;

    int vec_cnt;
    int err_cnt;

    // Reference model: a frame is simply a position in the byte stream
    logic [7:0] m_kernel [N_TAPS];
    logic [7:0] m_img    [N_PIX];
    logic [7:0] m_bias;
    int         m_pos;

    typedef struct {
        int n_beats;
        bit last_flag;
        int pat;
        bit gaps;
        bit exp_fv;
        bit exp_err;
    } vec_t;

    vec_t vecs [8];

    function automatic bit is_border(input int p);
`ifdef CONV_LOADER_ZERO_BORDER_EN
        int r, c;
        r = p / IMG_W;
        c = p % IMG_W;
        return (r == 0) || (r == IMG_H - 1) || (c == 0) || (c == IMG_W - 1);
`else
        return (p < 0);
`endif
    endfunction

    function automatic void model_reset();
        for (int t = 0; t < N_TAPS; t++) m_kernel[t] = 8'h00;
        for (int p = 0; p < N_PIX; p++) m_img[p] = 8'h00;
        m_bias = 8'h00;
        m_pos  = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] d, input logic l);
        bit fin;
        int p;
        fin = (m_pos == FRAME_LEN - 1);
        if (m_pos < N_TAPS) m_kernel[m_pos] = d;
        else if (m_pos == N_TAPS) m_bias = d;
        else begin
            p = m_pos - N_TAPS - 1;
            m_img[p] = is_border(p) ? 8'h00 : d;
        end
        if (l != fin || fin) m_pos = 0;
        else m_pos = m_pos + 1;
    endfunction

    function automatic logic [7:0] gen_byte(input int idx, input int pat);
        logic [7:0] b;
        if (pat == 1) b = 8'($urandom);
        else if (idx < N_TAPS) b = 8'(idx + 1);
        else if (idx == N_TAPS) b = 8'h05;
        else if (pat == 2) b = 8'hFF;
        else b = 8'((idx - N_TAPS - 1) % 256);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Compare each buffer at its first differing slot (slot 0 when all agree)
    task automatic check_buffers(input string tag);
        int  bi;
        bit  found;
        bi = 0; found = 0;
        for (int t = 0; t < N_TAPS; t++)
            if (!found && kernel[t*8 +: 8] !== m_kernel[t]) begin bi = t; found = 1; end
        check($sformatf("%s kernel[%0d]", tag, bi), 32'(kernel[bi*8 +: 8]), 32'(m_kernel[bi]));
        check($sformatf("%s bias", tag), 32'(bias), 32'(m_bias));
        bi = 0; found = 0;
        for (int p = 0; p < N_PIX; p++)
            if (!found && image_buffer[p*8 +: 8] !== m_img[p]) begin bi = p; found = 1; end
        check($sformatf("%s pixel[%0d]", tag, bi), 32'(image_buffer[bi*8 +: 8]), 32'(m_img[bi]));
    endtask

    // Called on a falling edge; returns on the falling edge after the beat is taken
    task automatic send_beat(input logic [7:0] d, input logic l, input bit gaps);
        int w;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        w = 0;
        while (!s_ready && w < 100) begin @(negedge clk); w++; end
        if (!s_ready) begin
            check("s_ready timeout", 32'(s_ready), 32'd1);
        end else begin
            @(negedge clk);
            model_accept(d, l);
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input int start, input int n, input bit last_flag, input int pat, input bit gaps);
        for (int i = start; i < n; i++) begin
            if (i == n - 1) check("frame_valid before final beat", 32'(frame_valid), 32'd0);
            send_beat(gen_byte(i, pat), (i == n - 1) ? last_flag : 1'b0, gaps);
        end
    endtask

    task automatic do_ack(input string tag);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check({tag, " frame_valid after ack"}, 32'(frame_valid), 32'd0);
        check({tag, " s_ready after ack"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        vec_cnt = 0; err_cnt = 0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; frame_ack = 1'b0; rst = 1'b1;
        model_reset();

        //              beats      last  pat gaps  fv    err
        vecs[0] = '{FRAME_LEN,    1'b1, 0, 1'b0, 1'b1, 1'b0};  // full gap-free frame
        vecs[1] = '{N_TAPS+1+101, 1'b1, 0, 1'b0, 1'b0, 1'b1};  // s_last on image beat 100
        vecs[2] = '{FRAME_LEN,    1'b1, 0, 1'b0, 1'b1, 1'b0};  // recovery after error
        vecs[3] = '{FRAME_LEN,    1'b0, 0, 1'b0, 1'b0, 1'b1};  // missing s_last
        vecs[4] = '{5,            1'b1, 1, 1'b0, 1'b0, 1'b1};  // s_last on a kernel tap
        vecs[5] = '{N_TAPS+1,     1'b1, 1, 1'b0, 1'b0, 1'b1};  // s_last on the bias
        vecs[6] = '{FRAME_LEN,    1'b1, 1, 1'b1, 1'b1, 1'b0};  // random data, random gaps
        vecs[7] = '{FRAME_LEN,    1'b1, 0, 1'b1, 1'b1, 1'b0};  // gapped copy of frame 0

        repeat (2) @(negedge clk);
        check("reset s_ready", 32'(s_ready), 32'd0);
        check("reset frame_valid", 32'(frame_valid), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check_buffers("reset");
        rst = 1'b0;
        check("s_ready right after reset", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("s_ready one cycle after reset", 32'(s_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            send_frame(0, vecs[i].n_beats, vecs[i].last_flag, vecs[i].pat, vecs[i].gaps);
            check($sformatf("v%0d frame_valid", i), 32'(frame_valid), 32'(vecs[i].exp_fv));
            check($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(!vecs[i].exp_fv));
            check_buffers($sformatf("v%0d", i));
            if (i == 0) begin
                for (int t = 0; t < N_TAPS; t++)
                    check($sformatf("v0 tap %0d", t), 32'(kernel[t*8 +: 8]), 32'(t + 1));
                check("v0 bias value", 32'(bias), 32'h05);
`ifndef CONV_LOADER_ZERO_BORDER_EN
                check("v0 pixel 783", 32'(image_buffer[(N_PIX-1)*8 +: 8]), 32'h0F);
`endif
            end
            @(negedge clk);
            check($sformatf("v%0d frame_err one-cycle", i), 32'(frame_err), 32'd0);
            check($sformatf("v%0d frame_valid held", i), 32'(frame_valid), 32'(vecs[i].exp_fv));
            if (vecs[i].exp_fv) do_ack($sformatf("v%0d", i));
        end

        // Hold with a pending beat: nothing consumed until the frame is released
        send_frame(0, FRAME_LEN, 1'b1, 1, 1'b0);
        s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0;
        repeat (20) @(negedge clk);
        check("hold s_ready", 32'(s_ready), 32'd0);
        check("hold frame_valid", 32'(frame_valid), 32'd1);
        check_buffers("hold");
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("release frame_valid", 32'(frame_valid), 32'd0);
        check("release s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        model_accept(8'hAA, 1'b0);
        check("held beat as tap 0", 32'(kernel[7:0]), 32'hAA);
        send_frame(1, FRAME_LEN, 1'b1, 0, 1'b0);
        check("after hold frame_valid", 32'(frame_valid), 32'd1);
        check_buffers("after hold");
        @(negedge clk);
        do_ack("after hold");

        // Asynchronous reset in the middle of image beat 400
        send_frame(0, N_TAPS + 1 + 400, 1'b0, 1, 1'b0);
        s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst s_ready", 32'(s_ready), 32'd0);
        check("midrst frame_valid", 32'(frame_valid), 32'd0);
        check("midrst frame_err", 32'(frame_err), 32'd0);
        check("midrst kernel zero", 32'(|kernel), 32'd0);
        check("midrst bias zero", 32'(|bias), 32'd0);
        check("midrst image zero", 32'(|image_buffer), 32'd0);
        model_reset();
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(0, FRAME_LEN, 1'b1, 1, 1'b1);
        check("post-reset frame_valid", 32'(frame_valid), 32'd1);
        check_buffers("post-reset");
        @(negedge clk);
        do_ack("post-reset");

`ifdef CONV_LOADER_ZERO_BORDER_EN
        // All-0xFF pixels: only the interior survives
        send_frame(0, FRAME_LEN, 1'b1, 2, 1'b0);
        check("border frame_valid", 32'(frame_valid), 32'd1);
        check("border pixel 0",   32'(image_buffer[0*8 +: 8]),   32'h00);
        check("border pixel 27",  32'(image_buffer[27*8 +: 8]),  32'h00);
        check("border pixel 28",  32'(image_buffer[28*8 +: 8]),  32'h00);
        check("border pixel 755", 32'(image_buffer[755*8 +: 8]), 32'h00);
        check("border pixel 783", 32'(image_buffer[783*8 +: 8]), 32'h00);
        check("border pixel 29",  32'(image_buffer[29*8 +: 8]),  32'hFF);
        check_buffers("border");
        @(negedge clk);
        do_ack("border");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/conv_frame_loader.md
Name: conv_frame_loader

Overview:
- Write side of the convolution engine's frame interface. Accepts a byte stream with valid/ready handshake and a last marker: 9 kernel taps, then 1 bias byte, then IMG_W*IMG_H pixels in row-major order.
- Assembles the flattened kernel, bias and image buffers that the conv2d stage consumes.
- Presents a complete frame with frame_valid and holds it stable until the consumer returns frame_ack.

Parameters:
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- PIX_W, 8, bits per pixel, kernel tap and bias.
- N_TAPS, 9, kernel taps (3x3).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- s_valid  input  1  stream beat valid.
- s_data  input  PIX_W  stream byte.
- s_last  input  1  marks the final image beat of a frame.
- s_ready  output  1  loader can accept a beat.
- frame_ack  input  1  consumer has latched the frame.
- frame_valid  output  1  kernel, bias and image_buffer are complete and stable.
- frame_err  output  1  one-cycle pulse on a framing error.
- image_buffer  output  PIX_W*IMG_W*IMG_H  pixel p = row*IMG_W+col at [p*PIX_W +: PIX_W].
- kernel  output  PIX_W*N_TAPS  tap t = ky*3+kx at [t*PIX_W +: PIX_W].
- bias  output  PIX_W  bias byte.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: state = S_KERNEL, beat counter = 0, s_ready = 0 for the reset cycle then 1, frame_valid = 0, frame_err = 0, image_buffer/kernel/bias all zero.
- Beat accepted iff s_valid && s_ready. s_ready = 1 in S_KERNEL, S_BIAS and S_IMAGE, and 0 in S_HOLD. s_ready is a registered output derived from state only, never from s_valid.
- S_KERNEL: accepted beat t written to kernel tap t. After tap N_TAPS-1, counter := 0 and state -> S_BIAS.
- S_BIAS: accepted beat written to bias, then -> S_IMAGE.
- S_IMAGE: accepted beat p written to pixel p, counter += 1.
  - Final beat (p = IMG_W*IMG_H-1) with s_last = 1: -> S_HOLD, and frame_valid = 1 from the next cycle.
- S_HOLD: all outputs frozen. On frame_ack = 1: frame_valid := 0, counter := 0, -> S_KERNEL next cycle.
  - Buffers keep old contents until overwritten.
  - frame_ack outside S_HOLD is ignored.
- Framing errors. Each causes a frame_err pulse for exactly one cycle (the cycle after the offending beat), counter := 0, state -> S_KERNEL, and no frame_valid. Already-written bytes are not cleared.
  - s_last = 1 on any beat other than the final image beat, in any loading state.
  - s_last = 0 on the final image beat.
- Latency: frame_valid rises exactly 1 cycle after acceptance of the final beat. Minimum frame time is N_TAPS+1+IMG_W*IMG_H accepted beats.
- Backpressure: no data loss. A beat with s_valid = 1 but s_ready = 0 (S_HOLD) is not consumed, and the source must hold it.
- Stall: s_valid = 0 gaps of any length are allowed, and the counter does not advance.
- Reset mid-frame: immediate return to the reset state, and the partial frame is discarded.
- Counter width: clog2(IMG_W*IMG_H). It never exceeds IMG_W*IMG_H-1 and never wraps.

Optional Feature:
- Macro: CONV_LOADER_ZERO_BORDER_EN.
- Defined: pixels with row = 0, row = IMG_H-1, col = 0 or col = IMG_W-1 are stored as 0 regardless of s_data. Beats are still accepted and counted, and s_last checking is unchanged.
- Undefined: all pixels are stored as received.

Test Plan:
- Full frame: taps 1..9, bias 0x05, pixel p = p mod 256, s_last on beat 783, no gaps. Required: kernel tap t = t+1, bias = 0x05, pixel 783 = 0x0F, frame_valid = 1 one cycle after beat 783, s_ready = 0.
- Hold/backpressure: drive s_valid = 1 with 0xAA while in S_HOLD for 20 cycles. Required: buffers unchanged, no beat consumed. Then pulse frame_ack: next cycle frame_valid = 0, s_ready = 1, and 0xAA is accepted as kernel tap 0.
- Early s_last: assert s_last on image beat 100. Required: frame_err pulses 1 cycle, frame_valid stays 0. A following correct frame then loads normally.
- Missing s_last: s_last = 0 on beat 783. Required: frame_err pulse, no frame_valid, state back to S_KERNEL.
- Reset mid-frame: assert rst asynchronously during image beat 400. Required: all outputs zero immediately. A subsequent full frame yields frame_valid after 794 accepted beats.
- Random s_valid gaps (~50% duty): required to produce buffers identical to the gap-free run.
- With CONV_LOADER_ZERO_BORDER_EN defined: feed all-0xFF pixels. Required: pixels 0, 27, 28, 755 and 783 = 0x00, pixel 29 = 0xFF.
